// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//   Parametrised multi-read-port register file for the single-cycle datapath.
//   After reset, a hardware sequencer clears every entry, one per edge. The
//   file is usable only once that sequence has finished. Writes requested
//   before then are dropped and recorded in a sticky flag.
//
//   Optional feature (compile-time macro REGFILE_BYPASS_EN):
//     defined   - a write in RUN is forwarded combinationally to any read
//                 port that addresses the same entry (write-through)
//     undefined - reads always return the array contents as of the last edge
//
// Parameters
//   DATA_W   bits per register
//   ADDR_W   address bits, DEPTH = 2**ADDR_W
//   NUM_RD   number of independent combinational read ports (1..4)
//   ZERO_REG 1 = entry 0 reads 0 and ignores writes
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_regwrite  write enable
//   i_wa        write address
//   i_wd        write data
//   i_ra        packed read addresses, port k = i_ra[k*ADDR_W +: ADDR_W]
//   o_rd        packed read data,      port k = o_rd[k*DATA_W +: DATA_W]
//   o_ready     1 = clear sequence finished
//   o_wr_drop   sticky: write requested while o_ready = 0
//
// State   | meaning
// --------+-----------------------------------------------------------
// CLEAR   | zeroing entry r_clr_idx each edge, file not usable
// RUN     | normal operation, writes through i_wa/i_wd
// ---------------------------------------------------------------------------
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_regwrite,
  input  logic [ADDR_W-1:0]        i_wa,
  input  logic [DATA_W-1:0]        i_wd,
  input  logic [NUM_RD*ADDR_W-1:0] i_ra,
  output logic [NUM_RD*DATA_W-1:0] o_rd,
  output logic                     o_ready,
  output logic                     o_wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic [ADDR_W-1:0]   w_clr_idx_nxt;
  logic                r_wr_drop;
  logic                w_wr_drop_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  // Single physical write port shared by the clear sequencer and the datapath
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_wa;
  logic [DATA_W-1:0]   w_mem_wd;

  // Write aimed at the hardwired zero entry
  logic                w_wr_zero;
  assign w_wr_zero = (ZERO_REG != 0) && (i_wa == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_wr_drop_nxt = r_wr_drop;
    w_mem_we      = 1'b0;
    w_mem_wa      = i_wa;
    w_mem_wd      = i_wd;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we      = 1'b1;
        w_mem_wa      = r_clr_idx;
        w_mem_wd      = '0;
        // Natural ADDR_W-bit overflow returns the index to 0 on the last entry
        w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
        if (i_regwrite) begin
          w_wr_drop_nxt = 1'b1;
        end
        if (r_clr_idx == {ADDR_W{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_mem_we = i_regwrite && !w_wr_zero;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Array has no reset; the clear sequencer provides the initial contents.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_mem_we) begin
      r_mem[w_mem_wa] <= w_mem_wd;
    end
  end

  assign o_ready   = (r_state == ST_RUN);
  assign o_wr_drop = r_wr_drop;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit_zero;
    logic              w_fwd;
    logic [DATA_W-1:0] w_rd;

    assign w_ra       = i_ra[k*ADDR_W +: ADDR_W];
    assign w_hit_zero = (ZERO_REG != 0) && (w_ra == '0);

`ifdef REGFILE_BYPASS_EN
    assign w_fwd = (r_state == ST_RUN) && i_regwrite && (i_wa == w_ra) && !w_wr_zero;
`else
    assign w_fwd = 1'b0;
`endif

    always_comb begin
      w_rd = '0;
      if ((r_state == ST_RUN) && !w_hit_zero) begin
        w_rd = w_fwd ? i_wd : r_mem[w_ra];
      end
    end

    assign o_rd[k*DATA_W +: DATA_W] = w_rd;
  end

endmodule
